vinstr_fifo: RTL and testbench



---
 rtl/vinstr_fifo_pkg.sv | 11 +
 rtl/fifo_s1_ctl.sv | 103 ++++++++++
 rtl/vinstr_fifo.sv | 75 +++++++
 tb/tb_vinstr_fifo.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/vinstr_fifo_pkg.sv
// Shared constants for the vector instruction queue: error-flag and reset behaviour selectors.
package vinstr_fifo_pkg;

  localparam int ERR_STICKY        = 0;
  localparam int ERR_STICKY_NODIAG = 1;
  localparam int ERR_DYNAMIC       = 2;

  localparam int RST_MEM   = 0;
  localparam int RST_NOMEM = 1;

endpackage

// File: rtl/fifo_s1_ctl.sv
// FIFO controller: read/write pointers, occupancy count, status flag decode and error tracking.
module fifo_s1_ctl
  import vinstr_fifo_pkg::*;
#(
  parameter int depth    = 8,
  parameter int ae_level = 1,
  parameter int af_level = depth - 1,
  parameter int err_mode = ERR_STICKY,
  localparam int AW      = $clog2(depth)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_req_n,
  input  logic          pop_req_n,
  input  logic          diag_n,
  output logic          we,
  output logic [AW-1:0] wr_addr,
  output logic [AW-1:0] rd_addr,
  output logic          empty,
  output logic          almost_empty,
  output logic          half_full,
  output logic          almost_full,
  output logic          full,
  output logic          error
);

  localparam int            CW      = $clog2(depth + 1);
  localparam logic [AW-1:0] LAST    = AW'(depth - 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(depth);
  localparam logic [CW-1:0] AE_C    = CW'(ae_level);
  localparam logic [CW-1:0] HF_C    = CW'((depth + 1) / 2);
  localparam logic [CW-1:0] AF_C    = CW'(depth - af_level);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          error_q, error_d;

  logic push, pop, diag_clr, is_empty, is_full;
  logic wr_ok, rd_ok, overflow, underflow;

  always_comb begin
    push      = ~push_req_n;
    pop       = ~pop_req_n;
    diag_clr  = (err_mode == ERR_STICKY) && !diag_n;
    is_empty  = (count_q == '0);
    is_full   = (count_q == DEPTH_C);
    // A simultaneous pop frees the slot, so a push into a full FIFO still succeeds.
    wr_ok     = push && (!is_full || pop) && !diag_clr;
    rd_ok     = pop && !is_empty && !diag_clr;
    overflow  = push && !pop && is_full && !diag_clr;
    underflow = pop && is_empty && !diag_clr;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    error_d  = error_q;

    if (diag_clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      error_d  = 1'b0;
    end else begin
      if (wr_ok) wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + AW'(1);
      if (rd_ok) rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (err_mode == ERR_DYNAMIC) error_d = overflow | underflow;
      else                         error_d = error_q | overflow | underflow;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      error_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      error_q  <= error_d;
    end
  end

  always_comb begin
    we           = wr_ok;
    wr_addr      = wr_ptr_q;
    rd_addr      = rd_ptr_q;
    empty        = (count_q == '0);
    almost_empty = (count_q <= AE_C);
    half_full    = (count_q >= HF_C);
    almost_full  = (count_q >= AF_C);
    full         = (count_q == DEPTH_C);
    error        = error_q;
  end

endmodule

// File: rtl/vinstr_fifo.sv
// Vector instruction queue: flip-flop FIFO with show-ahead output, status flags and error flag.
module vinstr_fifo
  import vinstr_fifo_pkg::*;
#(
  parameter int width    = 32,
  parameter int depth    = 8,
  parameter int ae_level = 1,
  parameter int af_level = depth - 1,
  parameter int err_mode = ERR_STICKY,
  parameter int rst_mode = RST_MEM
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_req_n,
  input  logic             pop_req_n,
  input  logic             diag_n,
  input  logic [width-1:0] data_in,
  output logic             empty,
  output logic             almost_empty,
  output logic             half_full,
  output logic             almost_full,
  output logic             full,
  output logic             error,
  output logic [width-1:0] data_out
);

  localparam int AW = $clog2(depth);

  logic             we;
  logic [AW-1:0]    wr_addr, rd_addr;
  logic [width-1:0] mem_q [depth];
  logic [width-1:0] mem_d [depth];

  fifo_s1_ctl #(
    .depth   (depth),
    .ae_level(ae_level),
    .af_level(af_level),
    .err_mode(err_mode)
  ) u_ctl (
    .clk         (clk),
    .rst         (rst),
    .push_req_n  (push_req_n),
    .pop_req_n   (pop_req_n),
    .diag_n      (diag_n),
    .we          (we),
    .wr_addr     (wr_addr),
    .rd_addr     (rd_addr),
    .empty       (empty),
    .almost_empty(almost_empty),
    .half_full   (half_full),
    .almost_full (almost_full),
    .full        (full),
    .error       (error)
  );

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[wr_addr] = data_in;
  end

  if (rst_mode == RST_MEM) begin : g_mem_rst
    always_ff @(posedge clk or posedge rst) begin
      if (rst) mem_q <= '{default: '0};
      else     mem_q <= mem_d;
    end
  end else begin : g_mem_keep
    // Storage keeps its contents through reset but must not capture a write while rst is high.
    always_ff @(posedge clk) begin
      if (!rst) mem_q <= mem_d;
    end
  end

  assign data_out = mem_q[rd_addr];

endmodule

// File: tb/tb_vinstr_fifo.sv
// Directed bench for vinstr_fifo: one sticky-error instance and one dynamic-error instance share stimulus.
module tb_vinstr_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        push_req_n = 1'b1;
  logic        pop_req_n = 1'b1;
  logic        diag_n = 1'b1;
  logic [31:0] data_in = '0;

  logic        a_empty, a_ae, a_hf, a_af, a_full, a_err;
  logic [31:0] a_dout;
  logic        b_empty, b_ae, b_hf, b_af, b_full, b_err;
  logic [31:0] b_dout;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  vinstr_fifo #(.width(32), .depth(8), .ae_level(1), .af_level(7), .err_mode(0), .rst_mode(0)) u_dut (
    .clk(clk), .rst(rst), .push_req_n(push_req_n), .pop_req_n(pop_req_n), .diag_n(diag_n),
    .data_in(data_in), .empty(a_empty), .almost_empty(a_ae), .half_full(a_hf),
    .almost_full(a_af), .full(a_full), .error(a_err), .data_out(a_dout)
  );

  vinstr_fifo #(.width(32), .depth(8), .ae_level(1), .af_level(7), .err_mode(2), .rst_mode(0)) u_dut_dyn (
    .clk(clk), .rst(rst), .push_req_n(push_req_n), .pop_req_n(pop_req_n), .diag_n(diag_n),
    .data_in(data_in), .empty(b_empty), .almost_empty(b_ae), .half_full(b_hf),
    .almost_full(b_af), .full(b_full), .error(b_err), .data_out(b_dout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag, input logic e, input logic ae, input logic hf,
                             input logic af, input logic f, input logic er);
    check({tag, ".empty"}, 32'(a_empty), 32'(e));
    check({tag, ".almost_empty"}, 32'(a_ae), 32'(ae));
    check({tag, ".half_full"}, 32'(a_hf), 32'(hf));
    check({tag, ".almost_full"}, 32'(a_af), 32'(af));
    check({tag, ".full"}, 32'(a_full), 32'(f));
    check({tag, ".error"}, 32'(a_err), 32'(er));
  endtask

  task automatic cycle(input logic push, input logic pop, input logic [31:0] din);
    push_req_n = ~push;
    pop_req_n  = ~pop;
    data_in    = din;
    @(posedge clk);
    #1;
    $display("txn t=%0t push=%0b pop=%0b diag_n=%0b din=0x%0h dout=0x%0h empty=%0b full=%0b err=%0b/%0b",
             $time, push, pop, diag_n, din, a_dout, a_empty, a_full, a_err, b_err);
    push_req_n = 1'b1;
    pop_req_n  = 1'b1;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    check_flags(tag, 1, 1, 0, 0, 0, 0);
    check({tag, ".data_out"}, a_dout, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] v;
    int k;

    #2 rst = 1'b1;
    #20 rst = 1'b0;
    @(posedge clk);
    #1;
    check_flags("reset", 1, 1, 0, 0, 0, 0);
    check("reset.data_out", a_dout, 32'h0);
    check("reset.dyn_error", 32'(b_err), 32'h0);

    // Fill to full: almost_full from 1 entry, half_full from 4, full at 8.
    for (int i = 0; i < 8; i++) begin
      v = 32'(i + 1) * 32'h11;
      cycle(1, 0, v);
      k = i + 1;
      check_flags($sformatf("fill%0d", k), 0, k <= 1, k >= 4, 1, k == 8, 0);
      check($sformatf("fill%0d.data_out", k), a_dout, 32'h11);
    end

    cycle(1, 0, 32'h99);
    check("ovf.error", 32'(a_err), 32'h1);
    check("ovf.dyn_error", 32'(b_err), 32'h1);
    check("ovf.full", 32'(a_full), 32'h1);
    check("ovf.data_out", a_dout, 32'h11);
    cycle(0, 0, 32'h0);
    check("ovf_hold.error", 32'(a_err), 32'h1);
    check("ovf_hold.dyn_error", 32'(b_err), 32'h0);

    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain%0d.data_out", i), a_dout, 32'(i + 1) * 32'h11);
      cycle(0, 1, 32'h0);
      check($sformatf("drain%0d.empty", i), 32'(a_empty), 32'(i == 7));
    end
    check("drain.error_sticky", 32'(a_err), 32'h1);

    do_reset("rst1");

    cycle(0, 1, 32'h0);
    check("udf.error", 32'(a_err), 32'h1);
    check("udf.dyn_error", 32'(b_err), 32'h1);
    check("udf.empty", 32'(a_empty), 32'h1);
    cycle(0, 0, 32'h0);
    check("udf_hold.error", 32'(a_err), 32'h1);
    check("udf_hold.dyn_error", 32'(b_err), 32'h0);

    // diag_n clears pointers/count/error in sticky mode only; storage survives.
    cycle(1, 0, 32'h31);
    cycle(1, 0, 32'h32);
    cycle(1, 0, 32'h33);
    diag_n = 1'b0;
    cycle(0, 0, 32'h0);
    diag_n = 1'b1;
    check_flags("diag", 1, 1, 0, 0, 0, 0);
    check("diag.data_out", a_dout, 32'h31);
    check("diag.dyn_empty", 32'(b_empty), 32'h0);
    check("diag.dyn_data_out", b_dout, 32'h31);

    do_reset("rst2");

    for (int i = 0; i < 8; i++) cycle(1, 0, 32'(i + 1) * 32'h11);
    cycle(1, 1, 32'hAA);
    check("pp.data_out", a_dout, 32'h22);
    check("pp.full", 32'(a_full), 32'h1);
    check("pp.error", 32'(a_err), 32'h0);
    check("pp.dyn_error", 32'(b_err), 32'h0);
    for (int i = 0; i < 8; i++) begin
      v = (i < 7) ? 32'(i + 2) * 32'h11 : 32'hAA;
      check($sformatf("pp_drain%0d.data_out", i), a_dout, v);
      cycle(0, 1, 32'h0);
    end
    check_flags("pp_drained", 1, 1, 0, 0, 0, 0);

    for (int i = 0; i < 20; i++) begin
      v = 32'h100 + 32'(i);
      cycle(1, 0, v);
      check($sformatf("wrap%0d.data_out", i), a_dout, v);
      check($sformatf("wrap%0d.empty_after_push", i), 32'(a_empty), 32'h0);
      cycle(0, 1, 32'h0);
      check($sformatf("wrap%0d.empty_after_pop", i), 32'(a_empty), 32'h1);
    end
    check("wrap.error", 32'(a_err), 32'h0);

    cycle(1, 0, 32'hC1);
    cycle(1, 0, 32'hC2);
    cycle(1, 0, 32'hC3);
    check("pre_async.empty", 32'(a_empty), 32'h0);
    #3;
    rst = 1'b1;
    #1;
    check_flags("async_rst", 1, 1, 0, 0, 0, 0);
    check("async_rst.data_out", a_dout, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
